rgb_led_pwm_mmio: RTL and testbench

- Memory-mapped peripheral directly downstream of tiny_cpu's store/load path.
- Turns SW data into per-channel PWM brightness on led_red/led_green/led_blue, replacing the CPU's direct LED bits.
- LW returns programmed register values so firmware can read back what it wrote.
- Sits on the single CLK domain beside data memory; selected by the CPU's address decode.

---
 rtl/rgb_led_pwm_mmio.sv | 197 +++++++++++++++++++
 tb/tb_rgb_led_pwm_mmio.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm_mmio.sv
// rgb_led_pwm_mmio: memory-mapped three-channel PWM LED driver.
// Registers: CTRL, DUTY_R/G/B, PRESCALE, BLINK, STATUS (read-only).
// Optional blink FSM is built when RGB_LED_PWM_BLINK_EN is defined.
module rgb_led_pwm_mmio #(
  parameter int PRESC_W = 16,
  parameter int DUTY_W  = 8,
  parameter int BLINK_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sel,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        led_red,
  output logic        led_green,
  output logic        led_blue
);

  logic [2:0]         reg_idx;
  logic               wr;
  logic [3:0]         ctrl_reg;
  logic [PRESC_W-1:0] prescale_reg;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [DUTY_W-1:0]  pwm_cnt_reg;
  logic [DUTY_W-1:0]  duty_reg   [3];
  logic [DUTY_W-1:0]  shadow_reg [3];
  logic [2:0]         led_reg;
  logic               en;
  logic               tick;
  logic               frame_end;
  logic               blink_on;
  logic               blink_phase;
  logic [31:0]        blink_rd;
  logic [31:0]        status_word;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  assign reg_idx   = addr[4:2];
  assign wr        = sel & we;
  assign en        = ctrl_reg[0];
  assign tick      = en & (presc_cnt_reg == prescale_reg);
  assign frame_end = tick & (pwm_cnt_reg == {DUTY_W{1'b1}});
  assign unused_bits = &{1'b0, wdata[31:PRESC_W], addr[1:0]};

  // CTRL and PRESCALE registers: only the field width is kept
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
    end else if (wr) begin
      if (reg_idx == 3'd0) ctrl_reg     <= wdata[3:0];
      if (reg_idx == 3'd4) prescale_reg <= wdata[PRESC_W-1:0];
    end
  end

  // Prescaler: held at 0 while disabled, restarted by any PRESCALE write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_cnt_reg <= '0;
    end else if (!en || (wr && reg_idx == 3'd4) || tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end
  end

  // PWM frame counter, wraps naturally at 2^DUTY_W
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt_reg <= '0;
    end else if (!en) begin
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  // Per-channel duty register, frame-synchronous shadow and output flop.
  // The shadow samples the pre-edge duty value, so a duty write landing on
  // the frame_end edge waits for the next frame boundary.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        duty_reg[gi]   <= '0;
        shadow_reg[gi] <= '0;
        led_reg[gi]    <= 1'b0;
      end else begin
        if (wr && reg_idx == 3'(gi + 1)) duty_reg[gi] <= wdata[DUTY_W-1:0];
        if (frame_end) shadow_reg[gi] <= duty_reg[gi];
        led_reg[gi] <= en & ctrl_reg[gi + 1] & blink_on &
                       (pwm_cnt_reg < shadow_reg[gi]);
      end
    end
  end

  assign led_red   = led_reg[0];
  assign led_green = led_reg[1];
  assign led_blue  = led_reg[2];

`ifdef RGB_LED_PWM_BLINK_EN
  typedef enum logic {BL_ON, BL_OFF} bl_state_t;

  bl_state_t          bl_state_reg, bl_state_next;
  logic [BLINK_W-1:0] blink_reg;
  logic [BLINK_W-1:0] bl_cnt_reg, bl_cnt_next;

  // BLINK register (frames per half-period)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_reg <= '0;
    end else if (wr && reg_idx == 3'd5) begin
      blink_reg <= wdata[BLINK_W-1:0];
    end
  end

  // Blink FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bl_state_reg <= BL_ON;
      bl_cnt_reg   <= '0;
    end else begin
      bl_state_reg <= bl_state_next;
      bl_cnt_reg   <= bl_cnt_next;
    end
  end

  // Blink FSM next state: counts frames, toggles every BLINK frames
  always_comb begin
    bl_state_next = bl_state_reg;
    bl_cnt_next   = bl_cnt_reg;
    if (!en) begin
      bl_state_next = BL_ON;
      bl_cnt_next   = '0;
    end else if (wr && reg_idx == 3'd5) begin
      bl_cnt_next   = '0;
    end else if (blink_reg == '0) begin
      bl_state_next = BL_ON;
      bl_cnt_next   = '0;
    end else if (frame_end) begin
      if (bl_cnt_reg == blink_reg - BLINK_W'(1)) begin
        bl_cnt_next   = '0;
        bl_state_next = (bl_state_reg == BL_ON) ? BL_OFF : BL_ON;
      end else begin
        bl_cnt_next   = bl_cnt_reg + 1'b1;
      end
    end
  end

  assign blink_on    = (bl_state_reg == BL_ON);
  assign blink_phase = (bl_state_reg == BL_OFF);
  assign blink_rd    = 32'(blink_reg);
`else
  logic [BLINK_W-1:0] unused_blink;

  assign unused_blink = '0;
  assign blink_on     = 1'b1;
  assign blink_phase  = 1'b0;
  assign blink_rd     = '0;
`endif

  // STATUS word: live PWM counter and blink phase
  always_comb begin
    status_word             = '0;
    status_word[DUTY_W-1:0] = pwm_cnt_reg;
    status_word[8]          = blink_phase;
  end

  // Read mux; DUTY reads return the programmed value, not the shadow
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      3'd0:    rd_mux = 32'(ctrl_reg);
      3'd1:    rd_mux = 32'(duty_reg[0]);
      3'd2:    rd_mux = 32'(duty_reg[1]);
      3'd3:    rd_mux = 32'(duty_reg[2]);
      3'd4:    rd_mux = 32'(prescale_reg);
      3'd5:    rd_mux = blink_rd;
      3'd6:    rd_mux = status_word;
      default: rd_mux = '0;
    endcase
  end

  // Registered read port: rdata holds between reads, rvalid pulses once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= sel & ~we;
      if (sel && !we) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_mmio.sv
// tb_rgb_led_pwm_mmio: bus register table plus timed PWM/shadow/blink sequences.
// Read expectations go through a scoreboard queue popped on rvalid.
module tb_rgb_led_pwm_mmio;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_DUTY_R = 5'h04;
  localparam logic [4:0] A_DUTY_G = 5'h08;
  localparam logic [4:0] A_DUTY_B = 5'h0C;
  localparam logic [4:0] A_PRESC  = 5'h10;
  localparam logic [4:0] A_BLINK  = 5'h14;
  localparam logic [4:0] A_STATUS = 5'h18;
  localparam logic [4:0] A_UNMAP  = 5'h1C;
`ifdef RGB_LED_PWM_BLINK_EN
  localparam logic [31:0] BLINK_EXP = 32'h0000_2345;
`else
  localparam logic [31:0] BLINK_EXP = 32'h0000_0000;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        led_red, led_green, led_blue;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl[21];

  rgb_led_pwm_mmio dut (
    .CLK(CLK), .RST(RST), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard: every rvalid must match the oldest queued expectation
  always @(negedge CLK) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = nm_q.pop_front();
        chk(n, rdata, e);
        $display("read %s: rdata=0x%0h expected=0x%0h", n, rdata, e);
      end
    end
  end

  task automatic drive_rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    sel = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
  endtask

  task automatic drive_idle();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK); drive_wr(a, d);
    @(negedge CLK); drive_idle();
    $display("write addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string nm);
    @(negedge CLK); drive_rd(a, e, nm);
    @(negedge CLK); drive_idle();
    @(negedge CLK);
    chk({nm, "_rvalid_pulse"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3, c4, c5, first_idx, other_hi, found;

    // ---------------- power-on reset ----------------
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_leds", {29'd0, led_red, led_green, led_blue}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    RST = 1'b0;
    bus_read(A_CTRL, 32'd0, "ctrl_after_reset");

    // ---------------- register table ----------------
    tbl[0]  = '{1'b1, A_PRESC,  32'hDEAD_1234, "wr_presc"};
    tbl[1]  = '{1'b0, A_PRESC,  32'h0000_1234, "presc_trunc"};
    tbl[2]  = '{1'b1, A_CTRL,   32'hFFFF_FF05, "wr_ctrl"};
    tbl[3]  = '{1'b0, A_CTRL,   32'h0000_0005, "ctrl_trunc"};
    tbl[4]  = '{1'b1, A_DUTY_R, 32'h00AB_CD12, "wr_duty_r"};
    tbl[5]  = '{1'b0, A_DUTY_R, 32'h0000_0012, "duty_r_rd"};
    tbl[6]  = '{1'b1, A_DUTY_G, 32'h0000_01FF, "wr_duty_g"};
    tbl[7]  = '{1'b0, A_DUTY_G, 32'h0000_00FF, "duty_g_rd"};
    tbl[8]  = '{1'b1, A_DUTY_B, 32'h0000_0080, "wr_duty_b"};
    tbl[9]  = '{1'b0, A_DUTY_B, 32'h0000_0080, "duty_b_rd"};
    tbl[10] = '{1'b1, A_BLINK,  32'h0001_2345, "wr_blink"};
    tbl[11] = '{1'b0, A_BLINK,  BLINK_EXP,     "blink_rd"};
    tbl[12] = '{1'b1, A_STATUS, 32'hFFFF_FFFF, "wr_status"};
    tbl[13] = '{1'b1, A_UNMAP,  32'hFFFF_FFFF, "wr_unmapped"};
    tbl[14] = '{1'b0, A_UNMAP,  32'h0000_0000, "unmapped_rd"};
    tbl[15] = '{1'b0, A_CTRL,   32'h0000_0005, "ctrl_after_ignored"};
    tbl[16] = '{1'b0, A_DUTY_R, 32'h0000_0012, "duty_r_after_ignored"};
    tbl[17] = '{1'b0, A_PRESC,  32'h0000_1234, "presc_after_ignored"};
    tbl[18] = '{1'b0, 5'h05,    32'h0000_0012, "duty_r_addr_lsb"};
    tbl[19] = '{1'b0, 5'h0F,    32'h0000_0080, "duty_b_addr_lsb"};
    tbl[20] = '{1'b1, A_CTRL,   32'h0000_0000, "stop"};
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].we) bus_write(tbl[i].addr, tbl[i].data);
      else bus_read(tbl[i].addr, tbl[i].data, tbl[i].name);
    end

    // ---------------- basic PWM, prescale 0 ----------------
    // Sample k = value after the k-th edge following the CTRL write.
    bus_write(A_PRESC, 32'd0);
    bus_write(A_DUTY_R, 32'd64);
    bus_write(A_CTRL, 32'h3);
    c0 = 0; c1 = 0; c2 = 0; other_hi = 0; first_idx = -1;
    for (int k = 0; k <= 768; k++) begin
      if (k > 0) @(negedge CLK);
      if (led_red && first_idx < 0) first_idx = k;
      if (led_green || led_blue) other_hi++;
      if (led_red) begin
        if (k <= 256) c0++;
        else if (k <= 512) c1++;
        else c2++;
      end
    end
    chk("pwm_first_frame_dark", c0, 0);
    chk("pwm_frame2_high", c1, 64);
    chk("pwm_frame3_high", c2, 64);
    chk("pwm_first_high_index", first_idx, 257);
    chk("pwm_green_blue_off", other_hi, 0);

    // ---------------- asynchronous reset mid-run ----------------
    bus_read(A_DUTY_R, 32'd64, "duty_r_before_reset");
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge CLK);
      if (led_red) found = 1;
    end
    chk("led_active_before_reset", found, 1);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_leds", {29'd0, led_red, led_green, led_blue}, 32'd0);
    chk("async_reset_rdata", rdata, 32'd0);
    chk("async_reset_rvalid", 32'(rvalid), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    bus_read(A_CTRL, 32'd0, "ctrl_after_async_reset");

    // ---------------- prescale 3 with boundary duties ----------------
    bus_write(A_PRESC, 32'd3);
    bus_write(A_DUTY_G, 32'd255);
    bus_write(A_DUTY_B, 32'd0);
    bus_write(A_CTRL, 32'hD);
    c0 = 0; c1 = 0; c2 = 0; other_hi = 0; first_idx = -1;
    for (int k = 0; k <= 3072; k++) begin
      if (k > 0) @(negedge CLK);
      if (led_blue || led_red) other_hi++;
      if (k <= 1024) begin
        if (led_green) c0++;
      end else if (k <= 2048) begin
        if (!led_green) begin
          c1++;
          if (first_idx < 0) first_idx = k;
        end
      end else begin
        if (!led_green) c2++;
      end
    end
    chk("presc_first_frame_dark", c0, 0);
    chk("presc_green_low_frame2", c1, 4);
    chk("presc_green_low_frame3", c2, 4);
    chk("presc_green_low_index", first_idx, 2045);
    chk("presc_blue_red_off", other_hi, 0);

    // ---------------- shadow timing and STATUS reads ----------------
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PRESC, 32'd0);
    bus_write(A_DUTY_R, 32'd64);
    bus_write(A_CTRL, 32'h3);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k <= 1024; k++) begin
      if (k > 0) @(negedge CLK);
      // write lands on edge 512 (a frame_end), read of DUTY_R on edge 513
      case (k)
        511: drive_wr(A_DUTY_R, 32'd200);
        512: drive_rd(A_DUTY_R, 32'd200, "duty_r_immediate");
        599: drive_rd(A_STATUS, 32'd87, "status_first");
        609: drive_rd(A_STATUS, 32'd97, "status_plus10");
        513, 600, 610: drive_idle();
        default: ;
      endcase
      if (led_red) begin
        if (k >= 257 && k <= 512) c0++;
        else if (k >= 513 && k <= 768) c1++;
        else if (k >= 769) c2++;
      end
    end
    chk("shadow_frame_a", c0, 64);
    chk("shadow_frame_old_duty", c1, 64);
    chk("shadow_frame_new_duty", c2, 200);

`ifdef RGB_LED_PWM_BLINK_EN
    // ---------------- blink, 2 frames per half-period ----------------
    bus_write(A_CTRL, 32'h0);
    bus_write(A_DUTY_R, 32'd128);
    bus_write(A_BLINK, 32'd2);
    bus_write(A_CTRL, 32'h3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0; c5 = 0;
    for (int k = 0; k <= 1705; k++) begin
      if (k > 0) @(negedge CLK);
      case (k)
        699:  drive_rd(A_STATUS, 32'h1BB, "status_blink_off");
        1099: drive_rd(A_STATUS, 32'h04B, "status_blink_on");
        1700: drive_wr(A_CTRL, 32'h0);
        1703: drive_rd(A_STATUS, 32'h000, "status_en_cleared");
        700, 1100, 1701, 1704: drive_idle();
        default: ;
      endcase
      if (led_red) begin
        if (k >= 1 && k <= 256) c0++;
        else if (k <= 512) c1++;
        else if (k <= 768) c2++;
        else if (k <= 1024) c3++;
        else if (k <= 1280) c4++;
        else if (k <= 1536) c5++;
      end
    end
    chk("blink_first_frame_old_shadow", c0, 200);
    chk("blink_frame2_on", c1, 128);
    chk("blink_frame3_off", c2, 0);
    chk("blink_frame4_off", c3, 0);
    chk("blink_frame5_on", c4, 128);
    chk("blink_frame6_on", c5, 128);
    chk("blink_led_off_after_en_clear", 32'(led_red), 32'd0);
`endif

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
